// File: rtl/phase_clock_gen_pkg.sv
// phase_clock_gen_pkg: shared FSM state type and phase-timer width for phase_clock_gen.
package phase_clock_gen_pkg;
   localparam int TMR_W = 8;
   typedef enum logic [2:0] {IDLE, PH1, DEAD1, PH2, DEAD2} phase_state_t;
endpackage

// File: rtl/phase_clock_gen_if.sv
// phase_clock_gen_if: run/step control and phase outputs of phase_clock_gen.
// i_step exists only when PHASE_CLOCK_GEN_STEP_EN is defined.
interface phase_clock_gen_if #(parameter int CNT_W = 16);
   logic             i_run;
`ifdef PHASE_CLOCK_GEN_STEP_EN
   logic             i_step;
`endif
   logic             o_phi1;
   logic             o_phi2;
   logic             o_phi2_last;
   logic             o_idle;
   logic [CNT_W-1:0] o_cycle_count;
`ifdef PHASE_CLOCK_GEN_STEP_EN
   modport master (output i_run, output i_step, input o_phi1, input o_phi2, input o_phi2_last, input o_idle, input o_cycle_count);
   modport slave  (input i_run, input i_step, output o_phi1, output o_phi2, output o_phi2_last, output o_idle, output o_cycle_count);
`else
   modport master (output i_run, input o_phi1, input o_phi2, input o_phi2_last, input o_idle, input o_cycle_count);
   modport slave  (input i_run, output o_phi1, output o_phi2, output o_phi2_last, output o_idle, output o_cycle_count);
`endif
endinterface

// File: rtl/phase_clock_gen_timer.sv
// phase_timer: loadable down-counter that holds at zero; o_one flags the last cycle before zero.
module phase_timer
   import phase_clock_gen_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_load,
   input  logic [TMR_W-1:0] i_load_val,
   output logic             o_zero,
   output logic             o_one
);
   logic [TMR_W-1:0] r_tmr;
   always_ff @(posedge i_clk or posedge i_reset)
      if (i_reset) r_tmr <= '0;
      else if (i_load) r_tmr <= i_load_val;
      else if (r_tmr != '0) r_tmr <= r_tmr - 1'b1;
   assign o_zero = r_tmr == '0;
   assign o_one  = r_tmr == TMR_W'(1);
endmodule

// File: rtl/phase_clock_gen.sv
// phase_clock_gen: two-phase non-overlapping phi1/phi2 generator with run/halt at cycle boundaries.
// Optional single-step control is built when PHASE_CLOCK_GEN_STEP_EN is defined.
module phase_clock_gen
   import phase_clock_gen_pkg::*;
#(
   parameter int PHASE_LEN = 2,
   parameter int DEAD_LEN  = 1,
   parameter int CNT_W     = 16
) (
   input  logic             i_clk,
   input  logic             i_reset,
   phase_clock_gen_if.slave bus
);
   localparam logic [TMR_W-1:0] PH_LD = TMR_W'(PHASE_LEN - 1);
   localparam logic [TMR_W-1:0] DT_LD = TMR_W'(DEAD_LEN - 1);
   if (PHASE_LEN < 1 || PHASE_LEN > 255 || DEAD_LEN < 0 || DEAD_LEN > 255) begin : g_bad_param
      $error("phase_clock_gen: PHASE_LEN must be 1..255 and DEAD_LEN 0..255");
   end
   phase_state_t     r_state, w_next;
   logic             r_phi1, r_phi2, r_last, r_idle;
   logic [CNT_W-1:0] r_cnt;
   logic             w_start, w_cont, w_load, w_zero, w_one;
   logic [TMR_W-1:0] w_ld_val;
`ifdef PHASE_CLOCK_GEN_STEP_EN
   // r_step marks a bus cycle started by i_step; it is re-evaluated on every idle cycle
   logic r_step;
   always_ff @(posedge i_clk or posedge i_reset)
      if (i_reset) r_step <= 1'b0;
      else if (r_state == IDLE) r_step <= bus.i_step & ~bus.i_run;
   assign w_start = bus.i_run | bus.i_step;
   assign w_cont  = bus.i_run & ~r_step;
`else
   assign w_start = bus.i_run;
   assign w_cont  = bus.i_run;
`endif
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_start) w_next = PH1;
         PH1:     if (w_zero) w_next = (DEAD_LEN == 0) ? PH2 : DEAD1;
         DEAD1:   if (w_zero) w_next = PH2;
         PH2:     if (w_zero) w_next = (DEAD_LEN != 0) ? DEAD2 : (w_cont ? PH1 : IDLE);
         DEAD2:   if (w_zero) w_next = w_cont ? PH1 : IDLE;
         default: w_next = IDLE;
      endcase
   end
   assign w_load   = w_next != r_state;
   assign w_ld_val = (w_next == PH1 || w_next == PH2) ? PH_LD : DT_LD;
   phase_timer u_timer (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_load     (w_load),
      .i_load_val (w_ld_val),
      .o_zero     (w_zero),
      .o_one      (w_one)
   );
   // outputs decode the next state so they change on the same edge as r_state
   always_ff @(posedge i_clk or posedge i_reset)
      if (i_reset) begin
         r_state <= IDLE;
         r_phi1  <= 1'b0;
         r_phi2  <= 1'b0;
         r_last  <= 1'b0;
         r_idle  <= 1'b1;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         r_phi1  <= w_next == PH1;
         r_phi2  <= w_next == PH2;
         r_last  <= w_next == PH2 && (w_load ? PHASE_LEN == 1 : w_one);
         r_idle  <= w_next == IDLE;
         r_cnt   <= r_cnt + CNT_W'(r_last);
      end
   assign bus.o_phi1        = r_phi1;
   assign bus.o_phi2        = r_phi2;
   assign bus.o_phi2_last   = r_last;
   assign bus.o_idle        = r_idle;
   assign bus.o_cycle_count = r_cnt;
endmodule

// File: tb/tb_phase_clock_gen.sv
// tb_phase_clock_gen: three parameterisations of phase_clock_gen checked against a cycle-position model.
module tb_phase_clock_gen;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   int   pl[3] = '{2, 1, 3};
   int   dl[3] = '{1, 0, 2};
   int   cw[3] = '{16, 16, 4};
   bit   act[3];
   int   p[3];
   int   cnt[3];
   bit   sf[3];
   always #5 clk = ~clk;
   phase_clock_gen_if #(.CNT_W(16)) if0 ();
   phase_clock_gen_if #(.CNT_W(16)) if1 ();
   phase_clock_gen_if #(.CNT_W(4))  if2 ();
   phase_clock_gen #(.PHASE_LEN(2), .DEAD_LEN(1), .CNT_W(16)) u0 (.i_clk(clk), .i_reset(rst), .bus(if0));
   phase_clock_gen #(.PHASE_LEN(1), .DEAD_LEN(0), .CNT_W(16)) u1 (.i_clk(clk), .i_reset(rst), .bus(if1));
   phase_clock_gen #(.PHASE_LEN(3), .DEAD_LEN(2), .CNT_W(4))  u2 (.i_clk(clk), .i_reset(rst), .bus(if2));
   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         act[k] = 0;
         p[k] = 0;
         cnt[k] = 0;
         sf[k] = 0;
      end
   endtask
   task automatic check_all();
      logic [3:0]  o[3];
      logic [31:0] c[3];
      logic [3:0]  e;
      o[0] = {if0.o_phi1, if0.o_phi2, if0.o_phi2_last, if0.o_idle};
      o[1] = {if1.o_phi1, if1.o_phi2, if1.o_phi2_last, if1.o_idle};
      o[2] = {if2.o_phi1, if2.o_phi2, if2.o_phi2_last, if2.o_idle};
      c[0] = 32'(if0.o_cycle_count);
      c[1] = 32'(if1.o_cycle_count);
      c[2] = 32'(if2.o_cycle_count);
      for (int k = 0; k < 3; k++) begin
         e = {act[k] && p[k] < pl[k],
              act[k] && p[k] >= pl[k] + dl[k] && p[k] < 2 * pl[k] + dl[k],
              act[k] && p[k] == 2 * pl[k] + dl[k] - 1,
              !act[k]};
         chk($sformatf("dut%0d {phi1,phi2,last,idle}", k), 32'(o[k]), 32'(e));
         chk($sformatf("dut%0d cycle_count", k), c[k], 32'(cnt[k]));
         chk($sformatf("dut%0d phi overlap", k), 32'(o[k][3] & o[k][2]), 0);
      end
   endtask
   // model: position p within a bus cycle of 2*PL+2*DL clocks, decisions taken at the boundary
   task automatic tick();
      logic r[3];
      logic s[3];
      logic rs;
      r = '{if0.i_run, if1.i_run, if2.i_run};
`ifdef PHASE_CLOCK_GEN_STEP_EN
      s = '{if0.i_step, if1.i_step, if2.i_step};
`else
      s = '{1'b0, 1'b0, 1'b0};
`endif
      rs = rst;
      @(posedge clk);
      if (rs) model_reset();
      else for (int k = 0; k < 3; k++) begin
         if (!act[k]) begin
            if (r[k] || s[k]) begin
               act[k] = 1;
               p[k] = 0;
               sf[k] = !r[k] && s[k];
            end
         end else begin
            if (p[k] == 2 * pl[k] + dl[k] - 1) cnt[k] = (cnt[k] + 1) % (1 << cw[k]);
            if (p[k] == 2 * pl[k] + 2 * dl[k] - 1) begin
               if (r[k] && !sf[k]) p[k] = 0;
               else begin
                  act[k] = 0;
                  sf[k] = 0;
               end
            end else p[k]++;
         end
      end
      #1 check_all();
   endtask
   task automatic async_reset();
      rst = 1'b1;
      #1;
      model_reset();
      check_all();
      tick();
      rst = 1'b0;
   endtask
   initial begin
      if0.i_run = 1'b1;
      if1.i_run = 1'b1;
      if2.i_run = 1'b1;
`ifdef PHASE_CLOCK_GEN_STEP_EN
      if0.i_step = 1'b0;
      if1.i_step = 1'b0;
      if2.i_step = 1'b0;
`endif
      model_reset();
      tick();
      tick();
      rst = 1'b0;
      repeat (21) tick();
      chk("dut1 count after 20 run cycles", 32'(if1.o_cycle_count), 10);
      repeat (400) begin
         if ($urandom_range(0, 15) == 0) if0.i_run = ~if0.i_run;
         if ($urandom_range(0, 15) == 0) if1.i_run = ~if1.i_run;
         if ($urandom_range(0, 15) == 0) if2.i_run = ~if2.i_run;
`ifdef PHASE_CLOCK_GEN_STEP_EN
         if0.i_step = $urandom_range(0, 7) == 0;
         if1.i_step = $urandom_range(0, 7) == 0;
         if2.i_step = $urandom_range(0, 7) == 0;
`endif
         tick();
      end
`ifdef PHASE_CLOCK_GEN_STEP_EN
      if0.i_step = 1'b0;
      if1.i_step = 1'b0;
      if2.i_step = 1'b0;
`endif
      if0.i_run = 1'b1;
      if1.i_run = 1'b0;
      if2.i_run = 1'b0;
      async_reset();
      repeat (13) tick();
      chk("dut0 in PH1 of cycle 3", 32'(if0.o_phi1), 1);
      if0.i_run = 1'b0;
      repeat (20) tick();
      chk("dut0 idle after run drop", 32'(if0.o_idle), 1);
      chk("dut0 count after run drop", 32'(if0.o_cycle_count), 3);
      if0.i_run = 1'b1;
      for (int i = 0; i < 20 && !(act[0] && p[0] >= pl[0] + dl[0] && p[0] < 2 * pl[0] + dl[0]); i++) tick();
      chk("dut0 reached PH2", 32'(if0.o_phi2), 1);
      async_reset();
      chk("dut0 phi2 after async reset", 32'(if0.o_phi2), 0);
      chk("dut0 idle after async reset", 32'(if0.o_idle), 1);
      if0.i_run = 1'b0;
      if2.i_run = 1'b1;
      repeat (170) tick();
      chk("dut2 count wrapped", 32'(if2.o_cycle_count), 1);
      if2.i_run = 1'b0;
`ifdef PHASE_CLOCK_GEN_STEP_EN
      repeat (12) tick();
      if0.i_step = 1'b1;
      tick();
      if0.i_step = 1'b0;
      repeat (2) tick();
      if0.i_step = 1'b1;
      tick();
      if0.i_step = 1'b0;
      repeat (10) tick();
      chk("dut0 count after single step", 32'(if0.o_cycle_count), 1);
      chk("dut0 idle after single step", 32'(if0.o_idle), 1);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
